// File: rtl/icache_pkg.sv
// Shared widths, parameter defaults and FSM state type for the instruction cache.
package icache_pkg;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_SETS           = 16;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int BYTE_OFF_W         = 2;
  localparam int DEF_IDX_W          = $clog2(DEF_SETS);
  localparam int DEF_OFF_W          = $clog2(DEF_WORDS_PER_LINE);
  localparam int DEF_TAG_W          = DEF_DATA_WIDTH - BYTE_OFF_W - DEF_OFF_W - DEF_IDX_W;

  typedef enum logic {IDLE, REFILL} icache_state_t;
endpackage

// File: rtl/icache_ctrl.sv
// Refill controller: miss FSM, word counter, memory request/address registers, pending flush.
// mem_addr holds the refill line's tag and index bits unchanged for the whole refill.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] line_base_i,
  input  logic                  mem_ack_i,
  output logic                  refill_o,
  output logic                  mem_req_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  fill_we_o,
  output logic [OFF_W-1:0]      fill_word_o,
  output logic                  line_done_o,
  output logic                  flush_all_o
);

  icache_state_t         state_q, state_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  flush_pend_q, flush_pend_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    flush_pend_d = flush_pend_q;
    fill_we_o    = 1'b0;
    line_done_o  = 1'b0;
    flush_all_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush_all_o = flush_i;
        if (miss_i) begin
          state_d    = REFILL;
          mem_req_d  = 1'b1;
          mem_addr_d = line_base_i;
          cnt_d      = '0;
        end
      end
      REFILL: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_ack_i) begin
          fill_we_o = 1'b1;
          if (cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            // A flush seen at any point of the refill also kills the line just filled.
            line_done_o  = 1'b1;
            flush_all_o  = flush_pend_q | flush_i;
            flush_pend_d = 1'b0;
            mem_req_d    = 1'b0;
            state_d      = IDLE;
          end else begin
            cnt_d      = cnt_q + OFF_W'(1);
            mem_addr_d = mem_addr_q + DATA_WIDTH'(4);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign refill_o    = (state_q == REFILL);
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign fill_word_o = cnt_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: same-cycle hit, word-by-word refill on miss.
module icache
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int SETS           = DEF_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC,
  input  logic                  req,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  hit,
  output logic                  stall_f,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = DATA_WIDTH - BYTE_OFF_W - OFF_W - IDX_W;
  localparam int IDX_LSB = BYTE_OFF_W + OFF_W;

  logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [SETS-1:0]       valid_q, valid_d;

  logic [TAG_W-1:0]      pc_tag;
  logic [IDX_W-1:0]      pc_idx;
  logic [OFF_W-1:0]      pc_off;
  logic [DATA_WIDTH-1:0] line_base;
  logic                  tag_match, refill, miss;
  logic                  fill_we, line_done, flush_all;
  logic [OFF_W-1:0]      fill_word;
  logic [IDX_W-1:0]      fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  unused_bits;

  assign pc_tag    = PC[DATA_WIDTH-1 -: TAG_W];
  assign pc_idx    = PC[IDX_LSB +: IDX_W];
  assign pc_off    = PC[BYTE_OFF_W +: OFF_W];
  assign line_base = {PC[DATA_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
  assign fill_idx  = mem_addr[IDX_LSB +: IDX_W];
  assign fill_tag  = mem_addr[DATA_WIDTH-1 -: TAG_W];
  assign unused_bits = ^{PC[BYTE_OFF_W-1:0], mem_addr[IDX_LSB-1:0]};

  assign tag_match = req & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
  assign hit       = tag_match & ~refill;
  assign miss      = req & ~tag_match;
  assign stall_f   = refill | miss;
  assign instr     = hit ? data_q[pc_idx][pc_off] : '0;

  icache_ctrl #(
    .DATA_WIDTH     (DATA_WIDTH),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_ctrl (
    .clk_i       (clk),
    .rst_i       (rst),
    .miss_i      (miss),
    .flush_i     (flush),
    .line_base_i (line_base),
    .mem_ack_i   (mem_ack),
    .refill_o    (refill),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .fill_we_o   (fill_we),
    .fill_word_o (fill_word),
    .line_done_o (line_done),
    .flush_all_o (flush_all)
  );

  always_comb begin
    valid_d = valid_q;
    if (flush_all)      valid_d = '0;
    else if (line_done) valid_d[fill_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Data and tags are plain storage with no reset; validity alone gates hits.
  always_ff @(posedge clk) begin
    if (!rst && fill_we)   data_q[fill_idx][fill_word] <= mem_rdata;
    if (!rst && line_done) tag_q[fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_icache.sv
// Directed plus random fetch sequences against a per-set reference model and a memory responder.
module tb_icache;
  localparam int SETS  = 16;
  localparam int WORDS = 4;

  logic        clk, rst, req, flush, hit, stall_f, mem_req, mem_ack;
  logic [31:0] PC, instr, mem_addr, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder state
  int          wait_cycles = 0;
  int          wait_cnt    = 0;
  int          unstable    = 0;
  bit          spur        = 0;
  bit          prev_wait   = 0;
  logic [31:0] prev_addr   = '0;
  logic [31:0] ack_addrs[$];

  // reference model: which line base each set holds
  bit          mvld  [SETS];
  logic [31:0] mbase [SETS];

  icache dut (
    .clk(clk), .rst(rst), .PC(PC), .req(req), .flush(flush),
    .instr(instr), .hit(hit), .stall_f(stall_f),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a >= 32'h10 && a <= 32'h1C) return 32'hA0 + ((a - 32'h10) >> 2);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  always @(negedge clk) begin
    bit gave;
    gave = 0;
    if (rst) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req === 1'b1) begin
      if (prev_wait && mem_addr !== prev_addr) unstable++;
      if (wait_cnt >= wait_cycles) begin
        mem_ack   = 1'b1;
        mem_rdata = memword(mem_addr);
        ack_addrs.push_back(mem_addr);
        wait_cnt  = 0;
        gave      = 1;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack   = spur;
      mem_rdata = 32'hBAD0_BAD0;
      wait_cnt  = 0;
    end
    prev_wait = (mem_req === 1'b1) && !rst && !gave;
    prev_addr = mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) mvld[s] = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input int waitc);
    int          set, n, a0;
    logic [31:0] base;
    bit          exp_hit;
    set     = int'((pc >> 4) % SETS);
    base    = pc & ~32'hF;
    exp_hit = mvld[set] && (mbase[set] == base);
    wait_cycles = waitc;
    a0 = ack_addrs.size();
    @(posedge clk); #1; PC = pc; req = 1'b1;
    @(negedge clk);
    check("hit", hit, exp_hit);
    if (exp_hit) begin
      check("hit_instr", instr, memword(pc & ~32'h3));
      check("hit_stall", stall_f, 0);
      check("hit_memreq", mem_req, 0);
    end else begin
      n = 0;
      while (stall_f === 1'b1 && n < 1000) begin
        n++;
        @(negedge clk);
      end
      check("stall_len", n, 1 + WORDS * (waitc + 1));
      check("ack_count", ack_addrs.size() - a0, WORDS);
      for (int i = 0; i < WORDS; i++)
        if (a0 + i < ack_addrs.size()) check("mem_addr", ack_addrs[a0 + i], base + 4 * i);
      check("refill_hit", hit, 1);
      check("refill_instr", instr, memword(pc & ~32'h3));
      mvld[set]  = 1;
      mbase[set] = base;
    end
    @(posedge clk); #1; req = 1'b0;
  endtask

  initial begin
    int a0, n;
    rst = 1'b1; req = 1'b0; flush = 1'b0; PC = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_memreq", mem_req, 0);
    check("rst_memaddr", mem_addr, 0);
    check("rst_stall", stall_f, 0);
    check("rst_hit", hit, 0);

    // cold miss, same-line hit, conflict eviction
    fetch(32'h10, 0);
    fetch(32'h1C, 0);
    fetch(32'h110, 0);
    fetch(32'h10, 0);

    // wait-state refill and hits on the filled line
    fetch(32'h40, 3);
    check("addr_stable", unstable, 0);
    fetch(32'h44, 0);
    fetch(32'h48, 0);

    // flush in IDLE: same-cycle lookup sees old contents
    @(posedge clk); #1; PC = 32'h44; req = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_same_hit", hit, 1);
    check("flush_same_instr", instr, memword(32'h44));
    @(posedge clk); #1; req = 1'b0; flush = 1'b0;
    model_clear();
    fetch(32'h44, 0);

    // flush during the 2nd refill word
    wait_cycles = 0;
    a0 = ack_addrs.size();
    @(posedge clk); #1; PC = 32'h200; req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; flush = 1'b1; req = 1'b0; PC = 32'h10;
    @(posedge clk); #1; flush = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("flushref_acks", ack_addrs.size() - a0, WORDS);
    check("flushref_memreq", mem_req, 0);
    model_clear();
    fetch(32'h200, 0);
    fetch(32'h40, 0);

    // acks with no outstanding request are ignored
    spur = 1;
    repeat (3) begin
      @(negedge clk);
      check("spur_memreq", mem_req, 0);
      check("spur_stall", stall_f, 0);
      check("spur_hit", hit, 0);
    end
    spur = 0;
    fetch(32'h204, 0);

    // reset after the 2nd refill ack
    fetch(32'h10, 0);
    wait_cycles = 0;
    a0 = ack_addrs.size();
    @(posedge clk); #1; PC = 32'h300; req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1; req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rstmid_acks", ack_addrs.size() - a0, 2);
    check("rstmid_memreq", mem_req, 0);
    check("rstmid_stall", stall_f, 0);
    check("rstmid_memaddr", mem_addr, 0);
    model_clear();
    fetch(32'h10, 0);
    fetch(32'h300, 0);

    // random fetch mix with occasional flushes
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        model_clear();
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      fetch(32'($urandom_range(0, 255)) << 2, int'($urandom_range(0, 2)));
    end
    check("addr_stable_end", unstable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache. It answers the fetch stage's PC lookups. A hit returns the instruction combinationally in the same cycle. A miss raises `stall_f`, which the fetch stage feeds into its PC-enable so the PC is held while the line is refilled word by word from main memory. It sits between the PC register and the fetch/decode pipeline register, and drives the only instruction-side port to main memory.

## Interface
- `DATA_WIDTH`, 32: instruction, address and memory data width.
- `SETS`, 16: number of lines, power of two; index bits = log2(SETS).
- `WORDS_PER_LINE`, 4: words per line, power of two; offset bits = log2(WORDS_PER_LINE).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `PC`  in  DATA_WIDTH: fetch address; bits [1:0] ignored.
- `req`  in  1: fetch request valid this cycle.
- `flush`  in  1: invalidate all lines (FENCE.I).
- `instr`  out  DATA_WIDTH: instruction word, valid when `hit`=1.
- `hit`  out  1: lookup hit (combinational).
- `stall_f`  out  1: fetch must hold PC; fetch stage drives `en_f = ~stall_f`.
- `mem_req`  out  1: word read request to main memory (registered).
- `mem_addr`  out  DATA_WIDTH: word-aligned read address (registered).
- `mem_rdata`  in  DATA_WIDTH: read data, valid with `mem_ack`.
- `mem_ack`  in  1: one word returned; may arrive after any number of wait cycles.

## Operation
- Address split: tag = PC[31 : 2+off+idx], index = PC[2+off+idx-1 : 2+off], offset = PC[2+off-1 : 2].
- Storage per line: valid bit, tag, and WORDS_PER_LINE data words. Storage is register based and read asynchronously.
- FSM states: IDLE, REFILL.
- IDLE:
  - `hit = req & valid[idx] & (tag_arr[idx]==tag)`.
  - `instr = data[idx][offset]` when `hit`, else 0.
  - `stall_f = req & ~hit`.
  - On a miss, the FSM registers the line base (PC with offset and byte bits cleared) into `mem_addr`, sets `mem_req`=1, clears the word counter, and enters REFILL.
- REFILL:
  - `stall_f`=1 and `hit`=0.
  - `mem_req` and `mem_addr` stay stable until `mem_ack`.
  - On each `mem_ack`, `data[idx_latched][cnt] <= mem_rdata`.
  - If cnt < WORDS_PER_LINE-1, the FSM increments cnt and adds 4 to `mem_addr`.
  - On the last word, the FSM writes tag and valid for the latched index, drops `mem_req`, and returns to IDLE.
- Refill index and tag are latched at miss time. A PC change during REFILL does not affect the refill in progress. After the refill, the new PC is looked up fresh in IDLE.
- Eviction: the refill overwrites whatever line occupies the index. There is no write-back because the cache is read-only.
- Flush in IDLE: all valid bits clear on the next edge. A lookup in the same cycle as flush uses the pre-flush contents.
- Flush in REFILL: the flush is recorded as pending. The refill completes its memory handshake. Then all valid bits clear, including the refilled line, and the FSM returns to IDLE.
- Reset, including reset mid-refill: FSM to IDLE, all valid bits 0, `mem_req`=0, `mem_addr`=0, cnt=0, pending flush=0. Data and tag arrays are not reset. Any outstanding memory word is abandoned; memory must tolerate this.

## Timing
- Hit latency: 0 cycles (same-cycle `instr`).
- Miss at cycle t, zero-wait memory (`mem_ack` asserted the first cycle `mem_req` is high, and every cycle after):
  - `stall_f` is high from t to t+WORDS_PER_LINE.
  - `mem_req` is high from t+1 to t+WORDS_PER_LINE.
  - In cycle t+WORDS_PER_LINE+1 the FSM is in IDLE, `hit`=1 and `stall_f`=0.
- With wait states, each word adds the number of cycles `mem_req` is held before its `mem_ack`.
- `mem_ack` while `mem_req`=0 is ignored.
- `req`=0: `hit`=0, `stall_f`=0 in IDLE, and no state change.

## Structure
- Package `icache_pkg`: parameter defaults, index/offset/tag width localparams, and the `icache_state_t` enum {IDLE, REFILL}.
- Sub-module `icache_ctrl`: FSM, word counter, `mem_req`/`mem_addr` registers, and pending-flush flag.
- Top-level `icache`: tag/valid/data arrays, hit compare, `instr` mux.

## Test plan
- Cold miss: reset, then req with PC=0x0000_0010 and zero-wait memory returning 0xA0..0xA3 → `stall_f` high for 5 cycles; `mem_addr` steps 0x10, 0x14, 0x18, 0x1C; then `hit`=1 and `instr`=0xA0.
- Same-line hit: after the cold miss, PC=0x1C → `hit`=1 in the same cycle, `instr`=0xA3, no `mem_req`.
- Conflict eviction: PC=0x0000_0010, then PC=0x0000_0110 (same index, different tag) → refill from 0x110; re-fetching 0x10 misses again.
- Wait states: `mem_ack` delayed 3 cycles per word → `mem_addr` stable during each wait; `stall_f` high for 17 cycles; correct words are stored.
- Flush: flush in IDLE → the next fetch of a cached PC misses. Flush asserted during the 2nd refill word → refill finishes all 4 acks, then the line is still invalid.
- Reset mid-refill: `rst`=1 after the 2nd ack → next cycle `mem_req`=0, `stall_f`=0 with `req`=0, and the previously filled line misses.
